// File: rtl/hpi_master.sv
// Host-port (HPI) bus master for the CY7C67200: sequences chip reset, then runs
// single read/write accesses with programmable setup/strobe/hold/recover timing.
module hpi_master #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int RST_CYC     = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        chip_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    inout  wire  [15:0] OTG_DATA,
    output logic [1:0]  OTG_ADDR,
    output logic        OTG_CS_N,
    output logic        OTG_RD_N,
    output logic        OTG_WR_N,
    output logic        OTG_RST_N,
    input  logic        OTG_INT,
    output logic        int_sync
);

    localparam int DATA_W = 16;
    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYC - 1);
    localparam logic [7:0] RST_LAST     = 8'(RST_CYC - 1);

    typedef enum logic [2:0] {
        RST_CHIP,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          phase_cnt;
    logic [7:0]          rst_cnt;
    logic                rst_pend;
    logic                wr_r;
    logic [1:0]          addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                drive_en;
    logic                int_p0;

    logic                rst_req;
    logic                accept;
    logic                acc_write;
    logic [1:0]          acc_addr;
    logic                next_bus;

    // A pending or same-cycle chip_reset outranks a new request in IDLE.
    always_comb begin
        rst_req    = rst_pend | chip_reset;
        req_ready  = (state == IDLE) && !rst_req;
        accept     = req_valid && req_ready;
        next_state = state;
        case (state)
            RST_CHIP: if (rst_cnt == RST_LAST) next_state = IDLE;
            IDLE: begin
                if (rst_req)        next_state = RST_CHIP;
                else if (req_valid) next_state = SETUP;
            end
            SETUP:   if (phase_cnt == SETUP_LAST)  next_state = STROBE;
            STROBE:  if (phase_cnt == STROBE_LAST) next_state = HOLD;
            HOLD:    if (phase_cnt == HOLD_LAST)   next_state = RECOVER;
            RECOVER: if (phase_cnt == RECOVER_LAST) next_state = rst_req ? RST_CHIP : IDLE;
            default: next_state = RST_CHIP;
        endcase
        acc_write = accept ? req_write : wr_r;
        acc_addr  = accept ? req_addr  : addr_r;
        next_bus  = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
    end

    // Bus pins are decoded from next_state so they change on the same edge as state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RST_CHIP;
            rst_cnt   <= 8'd0;
            phase_cnt <= 4'd0;
            rst_pend  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            OTG_ADDR  <= 2'd0;
            OTG_CS_N  <= 1'b1;
            OTG_RD_N  <= 1'b1;
            OTG_WR_N  <= 1'b1;
            OTG_RST_N <= 1'b0;
            drive_en  <= 1'b0;
            int_p0    <= 1'b0;
            int_sync  <= 1'b0;
        end else begin
            state     <= next_state;
            rst_cnt   <= (state == RST_CHIP && next_state == RST_CHIP) ? rst_cnt + 8'd1 : 8'd0;
            phase_cnt <= (next_state != state) ? 4'd0 : phase_cnt + 4'd1;
            if (next_state == RST_CHIP)
                rst_pend <= 1'b0;
            else if (chip_reset && state != IDLE && state != RST_CHIP)
                rst_pend <= 1'b1;
            rsp_valid <= (state == STROBE) && (next_state == HOLD);
            if (state == STROBE && next_state == HOLD && !wr_r)
                rsp_rdata <= OTG_DATA;
            OTG_ADDR  <= next_bus ? acc_addr : 2'd0;
            OTG_CS_N  <= !next_bus;
            OTG_RD_N  <= !(next_state == STROBE && !acc_write);
            OTG_WR_N  <= !(next_state == STROBE && acc_write);
            OTG_RST_N <= (next_state != RST_CHIP);
            drive_en  <= next_bus && acc_write;
            int_p0    <= OTG_INT;
            int_sync  <= int_p0;
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            wr_r    <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    assign OTG_DATA = drive_en ? wdata_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_hpi_master.sv
// Bench for hpi_master: directed scenarios plus random accesses, each cycle
// compared against a phase-window timing model of the host-port access.
module tb_hpi_master;

    localparam int S    = 1;
    localparam int T    = 4;
    localparam int H    = 1;
    localparam int R    = 2;
    localparam int RC   = 16;
    localparam int LAST = S + T + H + R + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        chip_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    tri1  [15:0] otg_data;
    logic [1:0]  otg_addr;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic        otg_rst_n;
    logic        otg_int;
    logic        int_sync;

    logic [15:0] chip_val;
    logic [15:0] exp_rdata;
    int          errors = 0;
    int          checks = 0;

    // Chip model: drives its read value only while RD_N is low; the bus pulls up otherwise.
    assign otg_data = !otg_rd_n ? chip_val : 16'hzzzz;

    always #5 clk = ~clk;

    hpi_master dut (
        .Clk        (clk),
        .Reset      (reset),
        .chip_reset (chip_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .OTG_DATA   (otg_data),
        .OTG_ADDR   (otg_addr),
        .OTG_CS_N   (otg_cs_n),
        .OTG_RD_N   (otg_rd_n),
        .OTG_WR_N   (otg_wr_n),
        .OTG_RST_N  (otg_rst_n),
        .OTG_INT    (otg_int),
        .int_sync   (int_sync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pins k cycles after the accept edge, from the phase windows.
    task automatic check_access(input string tag, input bit w, input logic [1:0] a,
                                input logic [15:0] d, input logic [15:0] rv, input int k);
        bit inb;
        bit strb;
        logic [15:0] bus_exp;
        inb  = (k >= 1) && (k <= S + T + H);
        strb = (k >= S + 1) && (k <= S + T);
        if (w && inb)       bus_exp = d;
        else if (!w && strb) bus_exp = rv;
        else                 bus_exp = 16'hFFFF;
        if (!w && k == S + T + 1) exp_rdata = rv;
        chk($sformatf("%s k%0d cs_n", tag, k), 32'(otg_cs_n), 32'(!inb));
        chk($sformatf("%s k%0d rd_n", tag, k), 32'(otg_rd_n), 32'(!(strb && !w)));
        chk($sformatf("%s k%0d wr_n", tag, k), 32'(otg_wr_n), 32'(!(strb && w)));
        chk($sformatf("%s k%0d addr", tag, k), 32'(otg_addr), 32'(inb ? a : 2'd0));
        chk($sformatf("%s k%0d bus", tag, k), 32'(otg_data), 32'(bus_exp));
        chk($sformatf("%s k%0d rsp_valid", tag, k), 32'(rsp_valid), 32'(k == S + T + 1));
        chk($sformatf("%s k%0d rsp_rdata", tag, k), 32'(rsp_rdata), 32'(exp_rdata));
        chk($sformatf("%s k%0d ready", tag, k), 32'(req_ready), 32'(k == LAST));
    endtask

    // Call with req_valid high and req_ready high in the current cycle.
    task automatic run_access(input string tag, input bit w, input logic [1:0] a,
                              input logic [15:0] d, input logic [15:0] rv);
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        for (int k = 1; k <= LAST; k++) begin
            check_access(tag, w, a, d, rv, k);
            if (k < LAST) tick();
        end
    endtask

    task automatic do_access(input string tag, input bit w, input logic [1:0] a,
                             input logic [15:0] d, input logic [15:0] rv);
        int n;
        chip_val  = rv;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " ready wait"}, 32'(req_ready), 32'd1);
        run_access(tag, w, a, d, rv);
    endtask

    // Current cycle is the first after the reset cause; walks the chip reset sequence.
    task automatic reset_seq_check(input string tag);
        for (int c = 1; c <= RC + 1; c++) begin
            if (c > 1) tick();
            chk($sformatf("%s c%0d rst_n", tag, c), 32'(otg_rst_n), 32'(c > RC));
            chk($sformatf("%s c%0d ready", tag, c), 32'(req_ready), 32'(c == RC + 1));
            chk($sformatf("%s c%0d cs_n", tag, c), 32'(otg_cs_n), 32'd1);
            chk($sformatf("%s c%0d bus", tag, c), 32'(otg_data), 32'hFFFF);
            chk($sformatf("%s c%0d rsp_valid", tag, c), 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc;
        int          cyc;
        int          run;
        int          min_run;
        bit          seen_low;
        int          acc_cyc[3];
        bit          rw;
        logic [1:0]  ra;
        logic [15:0] rd;
        logic [15:0] rrv;

        reset      = 1'b1;
        chip_reset = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 2'd0;
        req_wdata  = 16'd0;
        otg_int    = 1'b1;
        chip_val   = 16'd0;
        exp_rdata  = 16'd0;
        tick(); tick(); tick();

        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst addr", 32'(otg_addr), 32'd0);
        chk("rst cs_n", 32'(otg_cs_n), 32'd1);
        chk("rst rd_n", 32'(otg_rd_n), 32'd1);
        chk("rst wr_n", 32'(otg_wr_n), 32'd1);
        chk("rst rst_n", 32'(otg_rst_n), 32'd0);
        chk("rst bus", 32'(otg_data), 32'hFFFF);
        chk("rst int_sync", 32'(int_sync), 32'd0);

        reset   = 1'b0;
        otg_int = 1'b0;
        reset_seq_check("release");

        do_access("wr", 1'b1, 2'd2, 16'h1000, 16'h0000);
        do_access("rd", 1'b0, 2'd0, 16'h0000, 16'hBEEF);

        repeat (20) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("gap ready", 32'(req_ready), 32'd1);
                chk("gap cs_n", 32'(otg_cs_n), 32'd1);
            end
            rw  = 1'($urandom_range(0, 1));
            ra  = 2'($urandom_range(0, 3));
            rd  = 16'($urandom);
            rrv = 16'($urandom);
            do_access("rand", rw, ra, rd, rrv);
        end

        // Back-to-back writes with req_valid held high.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd1;
        n_acc = 0; cyc = 0; run = 0; min_run = 99; seen_low = 1'b0;
        while (n_acc < 3 && cyc < 60) begin
            if (req_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            req_wdata = 16'(16'h0100 * n_acc);
            tick();
            cyc++;
            if (!otg_cs_n) begin
                if (seen_low && run > 0 && run < min_run) min_run = run;
                run = 0;
                seen_low = 1'b1;
            end else begin
                run++;
            end
        end
        req_valid = 1'b0;
        chk("b2b accepts", 32'(n_acc), 32'd3);
        chk("b2b spacing 1-2", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
        chk("b2b spacing 2-3", 32'(acc_cyc[2] - acc_cyc[1]), 32'd9);
        chk("b2b cs gap>=2", 32'(min_run >= 2 && min_run != 99), 32'd1);
        repeat (LAST - 1) tick();
        chk("b2b ready after", 32'(req_ready), 32'd1);

        // chip_reset pulses mid-STROBE of a write; the two pulses merge into one reset.
        rd = 16'($urandom);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = rd;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < LAST; k++) begin
            check_access("crst", 1'b1, 2'd3, rd, 16'h0000, k);
            chip_reset = (k == 3) || (k == 5);
            tick();
        end
        chip_reset = 1'b0;
        for (int c = 1; c <= RC; c++) begin
            chk($sformatf("crst c%0d rst_n", c), 32'(otg_rst_n), 32'd0);
            chk($sformatf("crst c%0d ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("crst c%0d cs_n", c), 32'(otg_cs_n), 32'd1);
            if (c == 2) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; req_wdata = 16'h0;
                chip_val = 16'h5A5A;
            end
            tick();
        end
        chk("crst rst_n done", 32'(otg_rst_n), 32'd1);
        chk("crst ready done", 32'(req_ready), 32'd1);
        run_access("crst wait", 1'b0, 2'd1, 16'h0, 16'h5A5A);

        // chip_reset and req_valid together in IDLE: reset wins.
        chip_reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 16'hABCD;
        tick();
        chip_reset = 1'b0;
        req_valid = 1'b0;
        reset_seq_check("prio");

        // Reset asserted in cycle 3 of a read aborts it.
        chip_val = 16'h1234;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_access("abort", 1'b0, 2'd3, 16'h0, 16'h1234, k);
            if (k < 3) tick();
        end
        reset = 1'b1;
        tick();
        exp_rdata = 16'h0;
        chk("abort cs_n", 32'(otg_cs_n), 32'd1);
        chk("abort rd_n", 32'(otg_rd_n), 32'd1);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort rsp_rdata", 32'(rsp_rdata), 32'd0);
        tick();
        chk("abort rsp_valid 2", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        reset_seq_check("abort rel");

        otg_int = 1'b1;
        chk("int c0", 32'(int_sync), 32'd0);
        tick();
        chk("int c1", 32'(int_sync), 32'd0);
        tick();
        chk("int c2", 32'(int_sync), 32'd1);
        otg_int = 1'b0;
        tick();
        chk("int c3", 32'(int_sync), 32'd1);
        tick();
        chk("int c4", 32'(int_sync), 32'd0);

        repeat (5) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = 2'($urandom_range(0, 3));
            rd  = 16'($urandom);
            rrv = 16'($urandom);
            do_access("tail", rw, ra, rd, rrv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
